fu_completion_arbiter: RTL and testbench
========================================

Name: fu_completion_arbiter

Overview:
- Sits between the functional units and the reorder buffer's completion-marking inputs.
- Up to FU_COUNT FUs present finished instruction IDs with a valid/ready handshake. The arbiter grants up to WB_PORTS of them per cycle, using a rotating round-robin priority.
- Granted IDs are forwarded, registered, to the ROB completion ports.
- Provides fairness under writeback contention, a flush kill path, and a contention performance counter.

Parameters:
- FU_COUNT, 4, number of requesting functional units (>=2).
- WB_PORTS, 2, number of ROB completion ports (1..FU_COUNT).
- INST_ID_BITS, 6, width of ROB instruction IDs.
- CNT_BITS, 32, width of the contention counter.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  pipeline flush; kills grants and pending outputs.
- fu_valid[FU_COUNT]  in  1 each  FU i holds a completed instruction.
- fu_inst_id[FU_COUNT]  in  INST_ID_BITS each  ID of FU i's instruction.
- fu_ready[FU_COUNT]  out  1 each  combinational grant to FU i; transfer occurs when valid&&ready.
- rob_cpl_valid[WB_PORTS]  out  1 each  registered completion strobe to the ROB.
- rob_cpl_inst_id[WB_PORTS]  out  INST_ID_BITS each  registered completed ID.
- rr_ptr  out  clog2(FU_COUNT)  current highest-priority FU index (debug).
- contention_cycles  out  CNT_BITS  saturating count of contended cycles.

Behaviour:
- Reset (rst=1 at clock edge):
  - rr_ptr=0, all rob_cpl_valid=0, all rob_cpl_inst_id=0, contention_cycles=0.
  - fu_ready=0 combinationally while rst=1.
- FU handshake rules:
  - An FU holds fu_valid and fu_inst_id stable until it sees fu_ready=1.
  - fu_ready never depends on fu_ready of the same FU (no loops).
  - fu_ready[i]=1 only if fu_valid[i]=1.
- Grant selection (combinational, when rst=0 and flush=0):
  - Scan k=0..FU_COUNT-1 over FU index (rr_ptr+k) mod FU_COUNT.
  - Grant the first min(WB_PORTS, number valid) FUs with fu_valid=1.
- Port mapping:
  - The j-th grant in scan order maps to port j; ports beyond the grant count stay idle.
  - No two ports carry the same FU in one cycle.
- Latency is 1 cycle. At the next edge, rob_cpl_valid[j]=1 and rob_cpl_inst_id[j]=the granted ID. Idle ports get valid=0 and their ID holds its previous value.
- Pointer update:
  - If at least one grant was made, rr_ptr <= (index of last granted FU + 1) mod FU_COUNT.
  - If no grant was made, rr_ptr is unchanged.
  - Wrap-around is mandatory, e.g. FU_COUNT=4, last grant at FU 3 -> rr_ptr=0.
- Contention counter:
  - Increments by 1 in each cycle with rst=0, flush=0 and (number of fu_valid) > WB_PORTS.
  - Saturates at all-ones; never wraps.
- Flush:
  - While flush=1: all fu_ready=0; next-edge rob_cpl_valid=0 for all ports.
  - rr_ptr and contention_cycles are unchanged.
  - Completions registered in the cycle before flush still drive the outputs in the flush cycle; the ROB is responsible for ignoring them.
- Reset mid-operation: any pending registered output is dropped at the reset edge. FUs must re-present their instructions after reset; the arbiter keeps no memory of them.
- Fairness: under continuous requests from all FUs, every FU is granted at least once within ceil(FU_COUNT/WB_PORTS) cycles.
- Simultaneous rst and flush: rst wins.
- No combinational path from fu_* inputs to rob_cpl_* outputs.

Test Plan:
- Reset, then FU1 valid with id=5 for 1 cycle -> fu_ready[1]=1 in that cycle; next cycle rob_cpl_valid[0]=1, id=5, rob_cpl_valid[1]=0; rr_ptr=2.
- All 4 FUs valid continuously with ids 10,11,12,13, FUs dropping valid after their grant -> cycle0 grants FU0,FU1 (ports 0,1 = 10,11), rr_ptr=2; cycle1 grants FU2,FU3 (12,13), rr_ptr=0; contention_cycles=1.
- rr_ptr=3 and FUs 0 and 3 valid -> scan order 3,0; port0=FU3's id, port1=FU0's id; rr_ptr=1.
- 4 FUs valid, flush pulsed for 1 cycle -> fu_ready all 0 and no contention increment during the flush; next cycle rob_cpl_valid=0; rr_ptr unchanged; grants resume the following cycle.
- rst asserted in the same cycle as 3 valid FUs -> no fu_ready; next cycle all outputs 0, rr_ptr=0, counter=0.
- Force contention_cycles near saturation (CNT_BITS=4 build), then 20 contended cycles -> counter holds at 15.

Source files
------------

// File: rtl/fu_completion_arbiter.sv
// Round-robin completion arbiter. It grants up to WB_PORTS of FU_COUNT functional units per
// cycle and forwards the granted instruction IDs, registered, to the ROB completion ports.
module fu_completion_arbiter #(
  parameter int unsigned FU_COUNT     = 4,
  parameter int unsigned WB_PORTS     = 2,
  parameter int unsigned INST_ID_BITS = 6,
  parameter int unsigned CNT_BITS     = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic [FU_COUNT-1:0]          fu_valid,
  input  logic [INST_ID_BITS-1:0]      fu_inst_id [FU_COUNT],
  output logic [FU_COUNT-1:0]          fu_ready,
  output logic [WB_PORTS-1:0]          rob_cpl_valid,
  output logic [INST_ID_BITS-1:0]      rob_cpl_inst_id [WB_PORTS],
  output logic [$clog2(FU_COUNT)-1:0]  rr_ptr,
  output logic [CNT_BITS-1:0]          contention_cycles
);

  localparam int unsigned PtrW = $clog2(FU_COUNT);

  logic [PtrW-1:0]         rr_ptr_q, rr_ptr_d;
  logic [WB_PORTS-1:0]     cpl_valid_q, cpl_valid_d;
  logic [INST_ID_BITS-1:0] cpl_id_q [WB_PORTS];
  logic [INST_ID_BITS-1:0] cpl_id_d [WB_PORTS];
  logic [CNT_BITS-1:0]     cnt_q, cnt_d;
  int unsigned             gnt_cnt;
  logic                    contended;

  // Scan FUs in rotating priority order starting at rr_ptr; the j-th grant lands on port j.
  always_comb begin
    fu_ready    = '0;
    cpl_valid_d = '0;
    cpl_id_d    = cpl_id_q;
    rr_ptr_d    = rr_ptr_q;
    gnt_cnt     = 0;
    if (!rst && !flush) begin
      for (int unsigned k = 0; k < FU_COUNT; k++) begin
        for (int unsigned i = 0; i < FU_COUNT; i++) begin
          if ((i == (32'(rr_ptr_q) + k) % FU_COUNT) && fu_valid[i] && (gnt_cnt < WB_PORTS)) begin
            fu_ready[i] = 1'b1;
            for (int unsigned j = 0; j < WB_PORTS; j++) begin
              if (j == gnt_cnt) begin
                cpl_valid_d[j] = 1'b1;
                cpl_id_d[j]    = fu_inst_id[i];
              end
            end
            gnt_cnt  = gnt_cnt + 1;
            rr_ptr_d = PtrW'((i + 1) % FU_COUNT);
          end
        end
      end
    end
  end

  always_comb begin
    contended = !flush && ($countones(fu_valid) > WB_PORTS);
    cnt_d     = cnt_q;
    if (contended && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q    <= '0;
      cpl_valid_q <= '0;
      for (int unsigned j = 0; j < WB_PORTS; j++) begin
        cpl_id_q[j] <= '0;
      end
      cnt_q       <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      cpl_valid_q <= cpl_valid_d;
      for (int unsigned j = 0; j < WB_PORTS; j++) begin
        cpl_id_q[j] <= cpl_id_d[j];
      end
      cnt_q       <= cnt_d;
    end
  end

  assign rob_cpl_valid     = cpl_valid_q;
  assign rob_cpl_inst_id   = cpl_id_q;
  assign rr_ptr            = rr_ptr_q;
  assign contention_cycles = cnt_q;

endmodule

// File: tb/tb_fu_completion_arbiter.sv
// Directed bench for fu_completion_arbiter (4 FUs, 2 ports, 4-bit counter to reach saturation).
module tb_fu_completion_arbiter;

  localparam int unsigned FU_COUNT     = 4;
  localparam int unsigned WB_PORTS     = 2;
  localparam int unsigned INST_ID_BITS = 6;
  localparam int unsigned CNT_BITS     = 4;

  logic                    clk;
  logic                    rst;
  logic                    flush;
  logic [FU_COUNT-1:0]     fu_valid;
  logic [INST_ID_BITS-1:0] fu_inst_id [FU_COUNT];
  logic [FU_COUNT-1:0]     fu_ready;
  logic [WB_PORTS-1:0]     rob_cpl_valid;
  logic [INST_ID_BITS-1:0] rob_cpl_inst_id [WB_PORTS];
  logic [1:0]              rr_ptr;
  logic [CNT_BITS-1:0]     contention_cycles;

  int checks;
  int failures;

  fu_completion_arbiter #(
    .FU_COUNT     (FU_COUNT),
    .WB_PORTS     (WB_PORTS),
    .INST_ID_BITS (INST_ID_BITS),
    .CNT_BITS     (CNT_BITS)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .flush             (flush),
    .fu_valid          (fu_valid),
    .fu_inst_id        (fu_inst_id),
    .fu_ready          (fu_ready),
    .rob_cpl_valid     (rob_cpl_valid),
    .rob_cpl_inst_id   (rob_cpl_inst_id),
    .rr_ptr            (rr_ptr),
    .contention_cycles (contention_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; inputs change and outputs are sampled 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ids(input int a, input int b, input int c, input int d);
    fu_inst_id[0] = 6'(a);
    fu_inst_id[1] = 6'(b);
    fu_inst_id[2] = 6'(c);
    fu_inst_id[3] = 6'(d);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    flush    = 1'b0;
    fu_valid = 4'b1111;
    set_ids(1, 2, 3, 4);
    tick();
    tick();
    #1;
    chk("rst_ready", 32'(fu_ready), 32'h0);
    chk("rst_valid", 32'(rob_cpl_valid), 32'h0);
    chk("rst_id0", 32'(rob_cpl_inst_id[0]), 32'h0);
    chk("rst_id1", 32'(rob_cpl_inst_id[1]), 32'h0);
    chk("rst_ptr", 32'(rr_ptr), 32'h0);
    chk("rst_cnt", 32'(contention_cycles), 32'h0);

    // Single request from FU1.
    rst      = 1'b0;
    fu_valid = 4'b0010;
    set_ids(0, 5, 0, 0);
    #1;
    chk("single_ready", 32'(fu_ready), 32'b0010);
    tick();
    fu_valid = 4'b0000;
    chk("single_valid", 32'(rob_cpl_valid), 32'b01);
    chk("single_id0", 32'(rob_cpl_inst_id[0]), 32'd5);
    chk("single_ptr", 32'(rr_ptr), 32'd2);
    chk("single_cnt", 32'(contention_cycles), 32'd0);

    // Reset back to rr_ptr=0, then all four FUs request.
    rst = 1'b1;
    tick();
    rst      = 1'b0;
    fu_valid = 4'b1111;
    set_ids(10, 11, 12, 13);
    #1;
    chk("all_c0_ready", 32'(fu_ready), 32'b0011);
    tick();
    chk("all_c0_valid", 32'(rob_cpl_valid), 32'b11);
    chk("all_c0_id0", 32'(rob_cpl_inst_id[0]), 32'd10);
    chk("all_c0_id1", 32'(rob_cpl_inst_id[1]), 32'd11);
    chk("all_c0_ptr", 32'(rr_ptr), 32'd2);
    fu_valid = 4'b1100;
    #1;
    chk("all_c1_ready", 32'(fu_ready), 32'b1100);
    tick();
    fu_valid = 4'b0000;
    chk("all_c1_id0", 32'(rob_cpl_inst_id[0]), 32'd12);
    chk("all_c1_id1", 32'(rob_cpl_inst_id[1]), 32'd13);
    chk("all_c1_ptr", 32'(rr_ptr), 32'd0);
    chk("all_c1_cnt", 32'(contention_cycles), 32'd1);

    // Move pointer to 3 via a lone FU2 grant, then FU0 and FU3 compete across the wrap.
    fu_valid = 4'b0100;
    set_ids(30, 0, 20, 33);
    tick();
    chk("wrap_pre_ptr", 32'(rr_ptr), 32'd3);
    chk("idle_id1_hold", 32'(rob_cpl_inst_id[1]), 32'd13);
    fu_valid = 4'b1001;
    #1;
    chk("wrap_ready", 32'(fu_ready), 32'b1001);
    tick();
    chk("wrap_id0", 32'(rob_cpl_inst_id[0]), 32'd33);
    chk("wrap_id1", 32'(rob_cpl_inst_id[1]), 32'd30);
    chk("wrap_ptr", 32'(rr_ptr), 32'd1);

    // One-cycle flush with all FUs requesting.
    fu_valid = 4'b1111;
    set_ids(10, 11, 12, 13);
    flush    = 1'b1;
    #1;
    chk("flush_ready", 32'(fu_ready), 32'h0);
    chk("flush_prev_valid", 32'(rob_cpl_valid), 32'b11);
    tick();
    flush = 1'b0;
    chk("flush_valid", 32'(rob_cpl_valid), 32'b00);
    chk("flush_ptr", 32'(rr_ptr), 32'd1);
    chk("flush_cnt", 32'(contention_cycles), 32'd1);
    chk("flush_id0_hold", 32'(rob_cpl_inst_id[0]), 32'd33);
    #1;
    chk("resume_ready", 32'(fu_ready), 32'b0110);
    tick();
    chk("resume_id0", 32'(rob_cpl_inst_id[0]), 32'd11);
    chk("resume_id1", 32'(rob_cpl_inst_id[1]), 32'd12);
    chk("resume_ptr", 32'(rr_ptr), 32'd3);
    chk("resume_cnt", 32'(contention_cycles), 32'd2);

    // Reset together with flush and three valid FUs: reset wins.
    fu_valid = 4'b0111;
    rst      = 1'b1;
    flush    = 1'b1;
    #1;
    chk("rst_mid_ready", 32'(fu_ready), 32'h0);
    tick();
    chk("rst_mid_valid", 32'(rob_cpl_valid), 32'h0);
    chk("rst_mid_id0", 32'(rob_cpl_inst_id[0]), 32'h0);
    chk("rst_mid_id1", 32'(rob_cpl_inst_id[1]), 32'h0);
    chk("rst_mid_ptr", 32'(rr_ptr), 32'h0);
    chk("rst_mid_cnt", 32'(contention_cycles), 32'h0);

    // Twenty contended cycles saturate the 4-bit counter at 15.
    rst      = 1'b0;
    flush    = 1'b0;
    fu_valid = 4'b1111;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (c == 2) chk("sat_cnt3", 32'(contention_cycles), 32'd3);
      if (c == 3) chk("fair_ptr", 32'(rr_ptr), 32'd0);
    end
    chk("sat_cnt", 32'(contention_cycles), 32'd15);
    fu_valid = 4'b0000;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
